// File: rtl/data_mem_responder_pkg.sv
// Shared widths, memory-type encodings and FSM state encoding for the data memory responder.
// DMEM_WAIT_STATE_EN adds the WAIT state to the state encoding.
package data_mem_responder_pkg;

    localparam int DMEM_DWIDTH = 32;
    localparam int BYTE        = 8;
    localparam int HALF        = 16;

    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef DMEM_WAIT_STATE_EN
        ST_WAIT = 2'd1,
`endif
        ST_RESP = 2'd2
    } dmem_state_e;

    // Illegal type or misaligned halfword/word access.
    function automatic logic access_err(
        input logic [2:0] t,
        input logic [1:0] off
    );
        logic r;
        r = 1'b1;
        case (t)
            MT_B, MT_BU: r = 1'b0;
            MT_H, MT_HU: r = off[0];
            MT_W:        r = (off != 2'd0);
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Load lane select and sign/zero extension of a memory word.
// Combinational; used by data_mem_responder (see DMEM_WAIT_STATE_EN there).
module load_extend
    import data_mem_responder_pkg::*;
#(
    parameter int DWIDTH = DMEM_DWIDTH
)(
    input  logic [DWIDTH-1:0] i_word,
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_type,
    output logic [DWIDTH-1:0] o_data
);

    logic [DWIDTH-1:0] w_shift;
    logic [BYTE-1:0]   w_byte;
    logic [HALF-1:0]   w_half;

    assign w_shift = i_word >> {i_off, 3'b000};
    assign w_byte  = w_shift[BYTE-1:0];
    assign w_half  = w_shift[HALF-1:0];

    always_comb begin
        o_data = '0;
        case (i_type)
            MT_W:    o_data = i_word;
            MT_H:    o_data = {{(DWIDTH-HALF){w_half[HALF-1]}}, w_half};
            MT_HU:   o_data = {{(DWIDTH-HALF){1'b0}}, w_half};
            MT_B:    o_data = {{(DWIDTH-BYTE){w_byte[BYTE-1]}}, w_byte};
            MT_BU:   o_data = {{(DWIDTH-BYTE){1'b0}}, w_byte};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory with valid/ready requests and one-cycle response pulse.
// Define DMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states before each response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DWIDTH      = DMEM_DWIDTH,
    parameter int AWIDTH      = 12,
    parameter int WAIT_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NLANES = DWIDTH / BYTE;
    localparam int DEPTH  = 1 << (AWIDTH - 2);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be 1..15");
    end

    logic [DWIDTH-1:0] r_mem [DEPTH];

    dmem_state_e       r_state;
    logic              r_rsp_valid;
    logic [DWIDTH-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_err;
    logic [AWIDTH-3:0] w_idx;
    logic [1:0]        w_off;
    logic [NLANES-1:0] w_be;
    logic [DWIDTH-1:0] w_wdata;
    logic [DWIDTH-1:0] w_ldata;
    logic [DWIDTH-1:0] w_rsp_data;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[AWIDTH-1:2];
    assign w_off     = req_addr[1:0];
    assign w_err     = access_err(req_type, w_off);
    assign w_wdata   = req_wdata << {w_off, 3'b000};

    always_comb begin
        w_be = '0;
        case (req_type)
            MT_B, MT_BU: w_be = {{(NLANES-1){1'b0}}, 1'b1} << w_off;
            MT_H, MT_HU: w_be = {{(NLANES-2){1'b0}}, 2'b11} << w_off;
            MT_W:        w_be = '1;
            default:     w_be = '0;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_wen && !w_err) begin
            for (int b = 0; b < NLANES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*BYTE +: BYTE] <= w_wdata[b*BYTE +: BYTE];
                end
            end
        end
    end

    load_extend #(
        .DWIDTH (DWIDTH)
    ) u_load_extend (
        .i_word (r_mem[w_idx]),
        .i_off  (w_off),
        .i_type (req_type),
        .o_data (w_ldata)
    );

    assign w_rsp_data = (req_wen || w_err) ? '0 : w_ldata;

`ifdef DMEM_WAIT_STATE_EN
    logic [3:0]        r_wcnt;
    logic [DWIDTH-1:0] r_pend_data;
    logic              r_pend_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
            r_wcnt      <= '0;
            r_pend_data <= '0;
            r_pend_err  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef DMEM_WAIT_STATE_EN
                        r_state     <= ST_WAIT;
                        r_wcnt      <= '0;
                        r_pend_data <= w_rsp_data;
                        r_pend_err  <= w_err;
`else
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_data;
                        r_rsp_err   <= w_err;
`endif
                    end
                end
`ifdef DMEM_WAIT_STATE_EN
                ST_WAIT: begin
                    if (r_wcnt == 4'(WAIT_CYCLES - 1)) begin
                        r_state     <= ST_RESP;
                        r_wcnt      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pend_data;
                        r_rsp_err   <= r_pend_err;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
`endif
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
// Build with DMEM_WAIT_STATE_EN to exercise the WAIT_CYCLES=3 wait-state variant.
`timescale 1ns/1ps
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

`ifdef DMEM_WAIT_STATE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif
    localparam int PERIOD = LAT + 1;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wen   = 1'b0;
    logic [11:0] req_addr  = '0;
    logic [2:0]  req_type  = MT_W;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DWIDTH      (32),
        .AWIDTH      (12),
        .WAIT_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_type  (req_type),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One request; checks latency, data, error, busy and post-response idle.
    task automatic xact(input string tag, input logic wen,
                        input logic [11:0] addr, input logic [2:0] t,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_e);
        int          lat;
        logic        busy_ok;
        logic        idle_ok;
        logic [31:0] d;
        logic        e;
        @(negedge clk);
        check({tag, ".rdy"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_type  = t;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~wd;
        lat     = 1;
        busy_ok = 1'b1;
        idle_ok = 1'b1;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) busy_ok = 1'b0;
            if (rsp_rdata != 32'd0 || rsp_err) idle_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (req_ready) busy_ok = 1'b0;
        d = rsp_rdata;
        e = rsp_err;
        @(posedge clk);
        #1;
        if (rsp_valid || rsp_rdata != 32'd0 || rsp_err) idle_ok = 1'b0;
        check({tag, ".lat"}, 32'(lat), 32'(LAT));
        check({tag, ".data"}, d, exp_d);
        check({tag, ".err"}, {31'b0, e}, {31'b0, exp_e});
        check({tag, ".busy"}, {31'b0, busy_ok}, 32'd1);
        check({tag, ".idle"}, {31'b0, idle_ok}, 32'd1);
    endtask

    initial begin
        int          acc[$];
        logic [31:0] rsp[$];
        int          k;

        repeat (3) @(posedge clk);
        #1;
        check("rst.valid_in", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.ready", {31'b0, req_ready}, 32'd1);
        check("rst.valid", {31'b0, rsp_valid}, 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check("rst.err", {31'b0, rsp_err}, 32'd0);

        xact("stw",   1, 12'h010, MT_W,  32'hDEADBEEF, 32'h0,        0);
        xact("ldw",   0, 12'h010, MT_W,  32'h0,        32'hDEADBEEF, 0);
        xact("stb",   1, 12'h013, MT_B,  32'h00000080, 32'h0,        0);
        xact("ldb",   0, 12'h013, MT_B,  32'h0,        32'hFFFFFF80, 0);
        xact("ldbu",  0, 12'h013, MT_BU, 32'h0,        32'h00000080, 0);
        xact("ldw2",  0, 12'h010, MT_W,  32'h0,        32'h80ADBEEF, 0);
        xact("ldhmis",0, 12'h011, MT_H,  32'h0,        32'h0,        1);
        xact("ldw3",  0, 12'h010, MT_W,  32'h0,        32'h80ADBEEF, 0);
        xact("sthmis",1, 12'h011, MT_H,  32'h00001234, 32'h0,        1);
        xact("stwmis",1, 12'h012, MT_W,  32'h00000000, 32'h0,        1);
        xact("still", 1, 12'h010, 3'd7,  32'h00000000, 32'h0,        1);
        xact("ldill", 0, 12'h010, MT_X,  32'h0,        32'h0,        1);
        xact("ldw4",  0, 12'h010, MT_W,  32'h0,        32'h80ADBEEF, 0);
        xact("sth",   1, 12'h012, MT_H,  32'h0000A5A5, 32'h0,        0);
        xact("ldh",   0, 12'h012, MT_H,  32'h0,        32'hFFFFA5A5, 0);
        xact("ldhu",  0, 12'h012, MT_HU, 32'h0,        32'h0000A5A5, 0);
        xact("ldb1",  0, 12'h011, MT_B,  32'h0,        32'hFFFFFFBE, 0);
        xact("ldbu0", 0, 12'h010, MT_BU, 32'h0,        32'h000000EF, 0);
        xact("ldh0",  0, 12'h010, MT_H,  32'h0,        32'hFFFFBEEF, 0);
        xact("sth0",  1, 12'h010, MT_H,  32'hFFFF7F01, 32'h0,        0);
        xact("ldw5",  0, 12'h010, MT_W,  32'h0,        32'hA5A57F01, 0);
        xact("ldb2",  0, 12'h012, MT_B,  32'h0,        32'hFFFFFFA5, 0);

        for (int i = 0; i < 4; i++)
            xact("fill", 1, 12'h100 + 12'(4*i), MT_W, 32'h11110000 + 32'(i),
                 32'h0, 0);

        // Back-to-back: valid held high, junk stores while busy.
        k = 0;
        @(negedge clk);
        for (int c = 0; c < 4*PERIOD + 2; c++) begin
            if (req_ready) begin
                if (k < 4) begin
                    req_valid = 1'b1;
                    req_wen   = 1'b0;
                    req_type  = MT_W;
                    req_addr  = 12'h100 + 12'(4*k);
                    req_wdata = 32'h0;
                    acc.push_back(c);
                    k++;
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                req_valid = 1'b1;
                req_wen   = 1'b1;
                req_type  = MT_W;
                req_addr  = 12'h100 + 12'(4*(c%4));
                req_wdata = 32'h55555555;
            end
            @(posedge clk);
            #1;
            if (rsp_valid) rsp.push_back(rsp_rdata);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("bb.nacc", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++)
            check("bb.gap", 32'(acc[i] - acc[i-1]), 32'(PERIOD));
        check("bb.nrsp", 32'(rsp.size()), 32'd4);
        for (int i = 0; i < rsp.size(); i++)
            check("bb.data", rsp[i], 32'h11110000 + 32'(i));
        for (int i = 0; i < 4; i++)
            xact("bbchk", 0, 12'h100 + 12'(4*i), MT_W, 32'h0,
                 32'h11110000 + 32'(i), 0);

`ifdef DMEM_WAIT_STATE_EN
        begin
            logic seen;
            @(negedge clk);
            req_valid = 1'b1;
            req_wen   = 1'b1;
            req_addr  = 12'h200;
            req_type  = MT_W;
            req_wdata = 32'hCAFEF00D;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            check("wrst.busy", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            rst_n = 1'b0;
            seen  = 1'b0;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (rsp_valid) seen = 1'b1;
            end
            check("wrst.norsp", {31'b0, seen}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("wrst.ready", {31'b0, req_ready}, 32'd1);
            xact("wrst.ld", 0, 12'h200, MT_W, 32'h0, 32'hCAFEF00D, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 12, meaning byte-address width (4 KiB, 1024 words).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning extra response cycles; used only under DMEM_WAIT_STATE_EN; legal range 1..15.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit, meaning a request is present.
REQ-008 The block SHALL have port req_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-009 The block SHALL have port req_wen, input, 1 bit: 1 = store, 0 = load.
REQ-010 The block SHALL have port req_addr, input, AWIDTH bits, the byte address.
REQ-011 The block SHALL have port req_type, input, 3 bits, the memory type: MT_W, MT_H, MT_HU, MT_B or MT_BU.
REQ-012 The block SHALL have port req_wdata, input, DWIDTH bits, store data that is LSB-aligned.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, meaning a response is present for one cycle.
REQ-014 The block SHALL have port rsp_rdata, output, DWIDTH bits, load data after lane select and extension.
REQ-015 The block SHALL have port rsp_err, output, 1 bit, meaning the access was misaligned or req_type was illegal.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-018 A request SHALL be accepted only on a cycle where req_valid=1 and req_ready=1.
REQ-019 On acceptance, the FSM SHALL go IDLE->RESP; under DMEM_WAIT_STATE_EN it SHALL go IDLE->WAIT instead.
REQ-020 WAIT SHALL count WAIT_CYCLES cycles, then go WAIT->RESP; RESP SHALL go to IDLE after one cycle, unconditionally.
REQ-021 rsp_valid SHALL be 1 only in RESP; for acceptance at edge N, rsp_valid SHALL be high in cycle N+1, or N+1+WAIT_CYCLES when wait states are enabled.
REQ-022 Storage SHALL be a 1024 x DWIDTH array indexed by req_addr[AWIDTH-1:2]; the array SHALL not be reset.
REQ-023 A store SHALL commit on the acceptance edge, with byte lanes placed per addr[1:0]: MT_B writes 1 lane, MT_H writes 2 lanes, MT_W writes 4 lanes; all other lanes SHALL be unchanged.
REQ-024 A load SHALL capture the word on the acceptance edge and select the lane per addr[1:0]; MT_H and MT_B SHALL sign-extend, MT_HU and MT_BU SHALL zero-extend, and MT_W SHALL pass the word through.
REQ-025 An access SHALL be misaligned when it is MT_H/MT_HU with addr[0]=1, or MT_W with addr[1:0]!=0.
REQ-026 A misaligned access or an illegal req_type SHALL not write memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-027 A store response SHALL carry rsp_rdata=0 and rsp_err=0 when the store is legal.
REQ-028 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-029 Request inputs presented while req_ready=0 SHALL be ignored and SHALL not be captured.
REQ-030 Sustained throughput SHALL be one request per 2 cycles, or per 2+WAIT_CYCLES cycles when wait states are enabled.

Reset
REQ-031 Reset SHALL set state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-032 After reset, req_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-033 Reset in WAIT or RESP SHALL drop the pending response; a store already accepted SHALL remain committed.

Configuration
REQ-034 Macro DMEM_WAIT_STATE_EN SHALL control wait states; when defined, the WAIT state and its 4-bit counter SHALL exist and give latency 1+WAIT_CYCLES.
REQ-035 When DMEM_WAIT_STATE_EN is undefined, the WAIT state and counter SHALL be absent and latency SHALL be 1.

Structure
REQ-036 A shared package SHALL hold DWIDTH, the BYTE=8 and HALF=16 widths, the MT_W/MT_H/MT_HU/MT_B/MT_BU encodings and the FSM state encoding.
REQ-037 One combinational sub-module, load_extend, SHALL perform lane select plus sign/zero extension from (word, addr[1:0], type).

Verification
REQ-038 Store MT_W 0xDEADBEEF at 0x010, then load MT_W at 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 1 cycle after acceptance (wait states off).
REQ-039 Store MT_B 0x80 at 0x013, then load MT_B at 0x013 -> 0xFFFFFF80; load MT_BU -> 0x00000080; load MT_W at 0x010 -> 0x80ADBEEF.
REQ-040 Load MT_H at 0x011 -> rsp_err=1, rsp_rdata=0; a following load MT_W at 0x010 shows memory unchanged.
REQ-041 Hold req_valid=1 continuously with different addresses -> acceptances exactly every 2 cycles, and inputs changed during RESP are never captured.
REQ-042 With DMEM_WAIT_STATE_EN and WAIT_CYCLES=3, store then assert rst_n=0 in WAIT -> no rsp_valid; a later load returns the stored data.
REQ-043 With DMEM_WAIT_STATE_EN and WAIT_CYCLES=3, a single load -> rsp_valid at N+4, and req_ready=0 for cycles N+1..N+4.
